// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl
// Single-clock FIFO on an inferred dual-port RAM. The RAM has a registered read address
// and an asynchronous array read. Both ends use valid/ready handshakes. The read side is
// first-word-fall-through and can move one word per cycle.
//
// Optional feature macro: FIFO_PEAK_EN
//   Adds a peak-level tracker with a clear input.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   wr_valid     in   1       producer has a word on wr_data
//   wr_ready     out  1       FIFO accepts a word this cycle
//   wr_data      in   DATA    write word
//   rd_valid     out  1       head word present on rd_data
//   rd_ready     in   1       consumer takes the head word
//   rd_data      out  DATA    head word; don't-care while rd_valid=0
//   level        out  ADDR+1  stored word count, 0..DEPTH
//   almost_full  out  1       level >= AFULL_LVL
//   almost_empty out  1       level <= AEMPTY_LVL
//   peak_clr     in   1       (FIFO_PEAK_EN) load peak with the next level
//   peak         out  ADDR+1  (FIFO_PEAK_EN) highest level since reset or clear
module fifo_sync_ctrl #(
  parameter int DATA       = 8,
  parameter int ADDR       = 6,
  parameter int AFULL_LVL  = 60,
  parameter int AEMPTY_LVL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DATA-1:0] wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DATA-1:0] rd_data,
  output logic [ADDR:0]   level,
  output logic            almost_full,
  output logic            almost_empty
`ifdef FIFO_PEAK_EN
  ,
  input  logic            peak_clr,
  output logic [ADDR:0]   peak
`endif
);

  localparam int DEPTH = 1 << ADDR;
  localparam logic [ADDR:0]   LVL_FULL = DEPTH[ADDR:0];
  localparam logic [ADDR:0]   LVL_AF   = AFULL_LVL[ADDR:0];
  localparam logic [ADDR:0]   LVL_AE   = AEMPTY_LVL[ADDR:0];
  localparam logic [ADDR:0]   LVL_INC  = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR-1:0] PTR_INC  = {{(ADDR-1){1'b0}}, 1'b1};

  logic [DATA-1:0] mem [DEPTH];

  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR-1:0] raddr_q, raddr_d;
  logic [ADDR:0]   level_q, level_d;
  logic            almost_full_q, almost_full_d;
  logic            almost_empty_q, almost_empty_d;
  logic            wr_fire;
  logic            rd_fire;

  // Full and empty are decided only from the level counter.
  // A full FIFO refuses a write even when a read happens in the same cycle.
  assign wr_ready = ~rst & (level_q != LVL_FULL);
  assign rd_valid = ~rst & (level_q != '0);
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_fire  = rd_valid & rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_INC;
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_INC;
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + LVL_INC;
      2'b01:   level_d = level_q - LVL_INC;
      default: level_d = level_q;
    endcase
    // The read address always tracks the post-pop head. The next head word therefore
    // appears on rd_data in the cycle after a pop, which keeps full throughput.
    raddr_d        = rd_ptr_d;
    almost_full_d  = (level_d >= LVL_AF);
    almost_empty_d = (level_d <= LVL_AE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      raddr_q        <= '0;
      level_q        <= '0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      raddr_q        <= raddr_d;
      level_q        <= level_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // RAM write port. The contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= wr_data;
  end

  // A write into an empty FIFO targets the address that raddr_q already holds.
  // The asynchronous array read then shows the new word one cycle after the write.
  // A write never lands on raddr_q while the FIFO holds data. rd_data therefore stays
  // stable while the consumer stalls.
  assign rd_data      = mem[raddr_q];
  assign level        = level_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

`ifdef FIFO_PEAK_EN
  logic [ADDR:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (peak_clr) begin
      peak_d = level_d;
    end else if (level_d > peak_q) begin
      peak_d = level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
module tb_fifo_sync_ctrl;
  localparam int DATA  = 8;
  localparam int ADDR  = 6;
  localparam int DEPTH = 64;
  localparam int AF    = 60;
  localparam int AE    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_valid = 1'b0;
  logic            rd_ready = 1'b0;
  logic [DATA-1:0] wr_data = '0;
  logic            wr_ready;
  logic            rd_valid;
  logic [DATA-1:0] rd_data;
  logic [ADDR:0]   level;
  logic            almost_full;
  logic            almost_empty;
`ifdef FIFO_PEAK_EN
  logic            peak_clr = 1'b0;
  logic [ADDR:0]   peak;
`endif

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Reference model: the FIFO contents as a queue plus the peak value.
  byte unsigned mq[$];
  int           m_peak = 0;

  always #5 clk = ~clk;

  fifo_sync_ctrl #(
    .DATA(DATA), .ADDR(ADDR), .AFULL_LVL(AF), .AEMPTY_LVL(AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef FIFO_PEAK_EN
    ,
    .peak_clr     (peak_clr),
    .peak         (peak)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge. Inputs change here and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // On every negative edge, compare the DUT outputs with the model. Then advance the
  // model by the transfer that the coming rising edge performs.
  always @(negedge clk) begin
    int sz;
    bit exp_wr_ready, exp_rd_valid, wf, rf;
    if (mon_en) begin
      sz           = mq.size();
      exp_wr_ready = !rst && (sz < DEPTH);
      exp_rd_valid = !rst && (sz != 0);
      check("wr_ready",     32'(wr_ready),     32'(exp_wr_ready));
      check("rd_valid",     32'(rd_valid),     32'(exp_rd_valid));
      check("level",        32'(level),        32'(sz));
      check("almost_full",  32'(almost_full),  32'(sz >= AF));
      check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
      if (exp_rd_valid) check("rd_data", 32'(rd_data), 32'(mq[0]));
`ifdef FIFO_PEAK_EN
      check("peak", 32'(peak), 32'(m_peak));
`endif
      wf = wr_valid && exp_wr_ready;
      rf = rd_ready && exp_rd_valid;
      if (rst) begin
        mq.delete();
        m_peak = 0;
      end else begin
        if (rf) begin
          $display("RD %02h lvl=%0d", mq[0], sz);
          void'(mq.pop_front());
        end
        if (wf) begin
          $display("WR %02h lvl=%0d", wr_data, sz);
          mq.push_back(wr_data);
        end
`ifdef FIFO_PEAK_EN
        if (peak_clr) m_peak = mq.size();
        else if (mq.size() > m_peak) m_peak = mq.size();
`endif
      end
    end
  end

  initial begin
    int wp, rp;
    // Reset
    repeat (2) step();
    mon_en = 1'b1;
    step();
    check("rst_level", 32'(level), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    rst = 1'b0;
    step();
    check("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    // 1: fill 0x00..0x3F with no reads
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      step();
      if (i >= 58) check("af_edge", 32'(almost_full), (i >= 59) ? 32'd1 : 32'd0);
    end
    check("full_level", 32'(level), 32'd64);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    wr_data = 8'h40;
    step();
    check("w65_rejected", 32'(level), 32'd64);
    wr_valid = 1'b0;

    // 2: drain in order
    rd_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check("drain_data", 32'(rd_data), 32'(i));
      if (i >= 59) check("ae_edge", 32'(almost_empty), (i >= 60) ? 32'd1 : 32'd0);
      step();
    end
    rd_ready = 1'b0;
    check("drained_valid", 32'(rd_valid), 32'd0);
    check("drained_level", 32'(level), 32'd0);

    // 3: single write, visible one cycle later
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    step();
    wr_valid = 1'b0;
    check("lat_valid", 32'(rd_valid), 32'd1);
    check("lat_data", 32'(rd_data), 32'hA5);
    check("lat_level", 32'(level), 32'd1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;

    // 4: level 10, simultaneous read and write for 200 cycles
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      step();
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      wr_data = 8'(10 + k);
      check("stream_data", 32'(rd_data), 32'(k));
      check("stream_level", 32'(level), 32'd10);
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;

    // 5: grow to 30, then reset mid-burst
    for (int j = 0; j < 20; j++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'hC0 + j);
      step();
    end
    check("pre_rst_level", 32'(level), 32'd30);
    rd_ready = 1'b1;
    wr_data  = 8'hEE;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_valid", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;
    wr_data  = 8'h77;
    step();
    wr_data = 8'h78;
    step();
    wr_valid = 1'b0;
    check("after_rst_first", 32'(rd_data), 32'h77);
    check("after_rst_level", 32'(level), 32'd2);
    rd_ready = 1'b1;
    step();
    check("after_rst_second", 32'(rd_data), 32'h78);
    step();
    rd_ready = 1'b0;
    check("after_rst_empty", 32'(level), 32'd0);

`ifdef FIFO_PEAK_EN
    // 6: peak tracking
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    check("peak_clr0", 32'(peak), 32'd0);
    wr_valid = 1'b1;
    repeat (50) step();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (45) step();
    rd_ready = 1'b0;
    check("peak_lvl5", 32'(level), 32'd5);
    check("peak_50", 32'(peak), 32'd50);
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    check("peak_5", 32'(peak), 32'd5);
`endif

    // Randomised traffic in phases with different fill and drain bias, plus occasional resets
    for (int c = 0; c < 4000; c++) begin
      case ((c / 500) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 55; rp = 55; end
      endcase
      wr_valid = ($urandom_range(99) < wp);
      rd_ready = ($urandom_range(99) < rp);
      wr_data  = 8'($urandom);
      rst      = ($urandom_range(999) == 0);
`ifdef FIFO_PEAK_EN
      peak_clr = ($urandom_range(49) == 0);
`endif
      step();
    end
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
`ifdef FIFO_PEAK_EN
    peak_clr = 1'b0;
`endif
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
